// File: rtl/multi_edge_pkg.sv
// Shared defaults and helpers for the multi-channel edge detector.
package multi_edge_pkg;

    localparam int unsigned DEF_NUM_CH     = 4;
    localparam int unsigned DEF_DEB_CYCLES = 1;
    localparam int unsigned DEF_CNT_W      = 8;

    // Widest channel vector popcount accepts; narrower vectors are zero-extended.
    localparam int unsigned MAX_CH = 64;

    typedef logic [MAX_CH-1:0] ch_vec_t;

    function automatic logic [7:0] popcount(input ch_vec_t v);
        logic [7:0] n;
        n = '0;
        for (int unsigned i = 0; i < MAX_CH; i++) begin
            n = n + 8'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/edge_deb_ch.sv
// One channel: debounce filter on a synchronous input plus registered edge pulses.
module edge_deb_ch
    import multi_edge_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic a,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned    CW   = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0]  LAST = CW'(DEB_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            level <= 1'b0;
            cnt   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (a == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                // The DEB_CYCLES-th consecutive differing sample commits the new level.
                level <= a;
                cnt   <= '0;
                rise  <= a;
                fall  <= ~a;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/multi_edge_detect.sv
// Multi-channel debounced edge detector with sticky flags, interrupt and saturating event count.
module multi_edge_detect
    import multi_edge_pkg::*;
#(
    parameter int unsigned NUM_CH     = DEF_NUM_CH,
    parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] a_i,
    input  logic [NUM_CH-1:0] rise_en_i,
    input  logic [NUM_CH-1:0] fall_en_i,
    input  logic [NUM_CH-1:0] clr_i,
    input  logic              cnt_clr_i,
    output logic [NUM_CH-1:0] rising_edge_o,
    output logic [NUM_CH-1:0] falling_edge_o,
    output logic [NUM_CH-1:0] level_o,
    output logic [NUM_CH-1:0] sticky_o,
    output logic              irq_o,
    output logic [CNT_W-1:0]  count_o
);

    localparam int unsigned SUM_W = CNT_W + 8;

    logic [NUM_CH-1:0] ev;
    logic [7:0]        ev_cnt;
    logic [SUM_W-1:0]  sum;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        edge_deb_ch #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .a     (a_i[g]),
            .level (level_o[g]),
            .rise  (rising_edge_o[g]),
            .fall  (falling_edge_o[g])
        );
    end

    always_comb begin
        ev     = (rising_edge_o & rise_en_i) | (falling_edge_o & fall_en_i);
        ev_cnt = popcount(MAX_CH'(ev));
        sum    = SUM_W'(count_o) + SUM_W'(ev_cnt);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_o <= '0;
            irq_o    <= 1'b0;
            count_o  <= '0;
        end else begin
            // Set term OR'd last so a coincident event beats the clear.
            sticky_o <= (sticky_o & ~clr_i) | ev;
            irq_o    <= |sticky_o;
            if (cnt_clr_i) begin
                count_o <= '0;
            end else if (sum > SUM_W'({CNT_W{1'b1}})) begin
                count_o <= '1;
            end else begin
                count_o <= sum[CNT_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_multi_edge_detect.sv
// Scoreboard bench: a behavioural model queues expected outputs per cycle, a monitor compares.
module tb_multi_edge_detect;

    localparam int unsigned DEB = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] a, rise_en, fall_en, clr;
    logic       cnt_clr;

    logic [3:0] r8, f8, l8, s8;
    logic       irq8;
    logic [7:0] c8;
    logic [3:0] r2, f2, l2, s2;
    logic       irq2;
    logic [1:0] c2;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    multi_edge_detect #(.NUM_CH(4), .DEB_CYCLES(DEB), .CNT_W(8)) dut8 (
        .clk(clk), .reset(reset), .a_i(a), .rise_en_i(rise_en), .fall_en_i(fall_en),
        .clr_i(clr), .cnt_clr_i(cnt_clr), .rising_edge_o(r8), .falling_edge_o(f8),
        .level_o(l8), .sticky_o(s8), .irq_o(irq8), .count_o(c8)
    );

    multi_edge_detect #(.NUM_CH(4), .DEB_CYCLES(DEB), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .a_i(a), .rise_en_i(rise_en), .fall_en_i(fall_en),
        .clr_i(clr), .cnt_clr_i(cnt_clr), .rising_edge_o(r2), .falling_edge_o(f2),
        .level_o(l2), .sticky_o(s2), .irq_o(irq2), .count_o(c2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] rise, fall, level, sticky;
        logic       irq;
        logic [7:0] cnt8;
        logic [1:0] cnt2;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    logic [3:0]  m_level = '0, m_rise = '0, m_fall = '0, m_sticky = '0;
    logic        m_irq = 1'b0;
    int unsigned m_cnt8 = 0, m_cnt2 = 0;
    int unsigned m_run[4] = '{0, 0, 0, 0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_push();
        exp_t        e;
        logic [3:0]  ev;
        int unsigned n, c;
        if (reset) begin
            m_level = '0; m_rise = '0; m_fall = '0; m_sticky = '0; m_irq = 1'b0;
            m_cnt8 = 0; m_cnt2 = 0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
        end else begin
            ev = (m_rise & rise_en) | (m_fall & fall_en);
            n = $countones(ev);
            m_irq = |m_sticky;
            m_sticky = (m_sticky & ~clr) | ev;
            if (cnt_clr) begin
                m_cnt8 = 0; m_cnt2 = 0;
            end else begin
                c = m_cnt8 + n; m_cnt8 = (c > 255) ? 255 : c;
                c = m_cnt2 + n; m_cnt2 = (c > 3) ? 3 : c;
            end
            for (int i = 0; i < 4; i++) begin
                m_rise[i] = 1'b0;
                m_fall[i] = 1'b0;
                if (a[i] != m_level[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_level[i] = a[i];
                        m_rise[i]  = a[i];
                        m_fall[i]  = ~a[i];
                        m_run[i]   = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end
        e.rise = m_rise; e.fall = m_fall; e.level = m_level; e.sticky = m_sticky;
        e.irq = m_irq; e.cnt8 = 8'(m_cnt8); e.cnt2 = 2'(m_cnt2);
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            model_push();
            @(posedge clk);
            #2;
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check("rise",   32'(r8),   32'(mon_e.rise));
            check("fall",   32'(f8),   32'(mon_e.fall));
            check("level",  32'(l8),   32'(mon_e.level));
            check("sticky", 32'(s8),   32'(mon_e.sticky));
            check("irq",    32'(irq8), 32'(mon_e.irq));
            check("cnt8",   32'(c8),   32'(mon_e.cnt8));
            check("cnt2",   32'(c2),   32'(mon_e.cnt2));
            check("sticky2",32'(s2),   32'(mon_e.sticky));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; a = '0; rise_en = '1; fall_en = '1; clr = '0; cnt_clr = 1'b0;
        step(2);
        check("rst_level", 32'(l8), 32'h0);
        check("rst_count", 32'(c8), 32'h0);
        reset = 1'b0;

        // Single rising edge on ch0
        a = 4'b0001; step(2);
        check("s1_no_early", 32'(r8), 32'h0);
        step(1);
        check("s1_pulse", 32'(r8), 32'h1);
        step(2);
        check("s1_level",  32'(l8),   32'h1);
        check("s1_sticky", 32'(s8),   32'h1);
        check("s1_irq",    32'(irq8), 32'h1);
        check("s1_count",  32'(c8),   32'h1);

        // Glitch on ch1 shorter than the filter
        a = 4'b0011; step(2);
        a = 4'b0001; step(4);
        check("s2_level", 32'(l8), 32'h1);
        check("s2_count", 32'(c8), 32'h1);

        clr = 4'b0001; step(1);
        clr = 4'b0000; step(2);
        check("clr_sticky", 32'(s8),   32'h0);
        check("clr_irq",    32'(irq8), 32'h0);

        // Simultaneous rises with only ch0 enabled
        fall_en = 4'b0000; a = 4'b0000; step(5);
        rise_en = 4'b0001; fall_en = 4'b1111; a = 4'b0101; step(5);
        check("s3_level",  32'(l8), 32'h5);
        check("s3_sticky", 32'(s8), 32'h1);
        check("s3_count",  32'(c8), 32'h2);

        // Clear coinciding with a new enabled event on ch0
        rise_en = 4'b1111; a = 4'b0100; step(3);
        clr = 4'b0001; step(1);
        clr = 4'b0000; step(1);
        check("s4_set_wins", 32'(s8), 32'h1);
        check("s4_count",    32'(c8), 32'h3);
        clr = 4'b0001; step(1);
        clr = 4'b0000; step(1);
        check("s4_cleared", 32'(s8),   32'h0);
        check("s4_irq_low", 32'(irq8), 32'h0);

        // Saturation and counter clear
        a = 4'b1111; step(5);
        check("s5_cnt8", 32'(c8), 32'd6);
        check("s5_sat2", 32'(c2), 32'd3);
        a = 4'b0000; step(3);
        cnt_clr = 1'b1; step(1);
        cnt_clr = 1'b0; step(2);
        check("s5_clr8",   32'(c8), 32'd0);
        check("s5_clr2",   32'(c2), 32'd0);
        check("s5_sticky", 32'(s8), 32'hf);
        a = 4'b1111; step(5);
        a = 4'b0000; step(5);
        check("s5_hold2", 32'(c2), 32'd3);
        check("s5_cnt8b", 32'(c8), 32'd8);

        // Reset in the middle of a debounce
        a = 4'b1000; step(2);
        reset = 1'b1; step(1);
        check("s6_rst_level",  32'(l8),   32'h0);
        check("s6_rst_sticky", 32'(s8),   32'h0);
        check("s6_rst_irq",    32'(irq8), 32'h0);
        check("s6_rst_count",  32'(c8),   32'h0);
        reset = 1'b0; step(2);
        check("s6_no_early", 32'(r8), 32'h0);
        step(1);
        check("s6_pulse", 32'(r8), 32'h8);
        check("s6_level", 32'(l8), 32'h8);

        // Random traffic against the model
        for (int k = 0; k < 300; k++) begin
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 4) == 0) a[b] = ~a[b];
            rise_en = 4'($urandom);
            fall_en = 4'($urandom);
            clr     = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
            cnt_clr = ($urandom_range(0, 15) == 0);
            reset   = ($urandom_range(0, 63) == 0);
            step(1);
        end
        reset = 1'b0;

        for (int w = 0; w < 5 && sb.size() > 0; w++) @(posedge clk);
        #2;
        check("drain", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
